// File: rtl/mem_resp_stage.sv
// MEM stage: holds one EX instruction, waits for its data-SRAM response, extracts load data and
// drops responses of flushed loads. Optional macro MEM_LOAD_FWD_EN forwards finished load data on bypass.
module mem_resp_stage #(
    parameter int DISCARD_MAX = 3,
    parameter int CNT_W       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_ready_go,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_result,
    input  logic        in_rf_we,
    input  logic [4:0]  in_rf_waddr,
    input  logic [4:0]  in_ld_ctrl,
    input  logic        in_req,
    input  logic        flush,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        mem_allow_in,
    input  logic        wb_allow_in,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic        out_rf_we,
    output logic [4:0]  out_rf_waddr,
    output logic [31:0] out_pc,
    output logic [4:0]  byp_waddr,
    output logic        byp_we,
    output logic        byp_busy,
    output logic [31:0] byp_data
);

    localparam int LD_W  = 4;
    localparam int LD_B  = 3;
    localparam int LD_BU = 2;
    localparam int LD_H  = 1;
    localparam int LD_HU = 0;

    generate
        if (DISCARD_MAX < 1 || DISCARD_MAX > 15 || (1 << CNT_W) <= DISCARD_MAX) begin : g_bad_param
            $error("mem_resp_stage: DISCARD_MAX must be 1..15 and fit in CNT_W bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_discard;
    logic [31:0]       r_pc;
    logic [31:0]       r_result;
    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;
    logic [4:0]        r_ld_ctrl;
    logic [31:0]       r_rdata;

    logic              w_cnt_zero;
    logic              w_cnt_full;
    logic              w_ready_go;
    logic              w_allow_in;
    logic              w_load;
    logic              w_resp_ours;
    logic              w_resp_stale;
    logic              w_orphan;
    state_t            w_entry_state;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;
    logic              w_is_load;

    assign w_cnt_zero    = (r_discard == '0);
    assign w_cnt_full    = (r_discard == CNT_W'(DISCARD_MAX));
    assign w_ready_go    = (r_state == ST_DONE);
    // A new request must not enter while responses of flushed loads are still in flight,
    // otherwise its own response could not be told apart from a stale one.
    assign w_allow_in    = ((r_state == ST_EMPTY) | (w_ready_go & wb_allow_in))
                           & ~(~w_cnt_zero & in_req);
    assign w_load        = in_valid & in_ready_go & w_allow_in & ~flush;
    assign w_resp_ours   = data_sram_data_ok & w_cnt_zero & (r_state == ST_WAIT);
    assign w_resp_stale  = data_sram_data_ok & ~w_cnt_zero;
    assign w_orphan      = flush & (r_state == ST_WAIT) & ~w_resp_ours;
    assign w_entry_state = in_req ? ST_WAIT : ST_DONE;
    assign w_is_load     = (r_ld_ctrl != 5'b00000);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_discard  <= '0;
            r_pc       <= '0;
            r_result   <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_ld_ctrl  <= '0;
            r_rdata    <= '0;
        end else begin
            // A flushed request and a stale response in the same cycle cancel out.
            if (w_orphan && !w_resp_stale) begin
                if (!w_cnt_full) begin
                    r_discard <= r_discard + CNT_W'(1);
                end
            end else if (w_resp_stale && !w_orphan) begin
                r_discard <= r_discard - CNT_W'(1);
            end

            if (w_resp_ours) begin
                r_rdata <= data_sram_rdata;
            end

            if (w_load) begin
                r_pc       <= in_pc;
                r_result   <= in_result;
                r_rf_we    <= in_rf_we;
                r_rf_waddr <= in_rf_waddr;
                r_ld_ctrl  <= in_ld_ctrl;
            end

            case (r_state)
                ST_EMPTY: begin
                    if (w_load) begin
                        r_state <= w_entry_state;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        r_state <= ST_EMPTY;
                    end else if (w_resp_ours) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (flush) begin
                        r_state <= ST_EMPTY;
                    end else if (w_load) begin
                        r_state <= w_entry_state;
                    end else if (wb_allow_in) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = r_rdata[7:0];
        case (r_result[1:0])
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            2'd3:    w_byte = r_rdata[31:24];
            default: w_byte = r_rdata[7:0];
        endcase
        w_half = r_result[1] ? r_rdata[31:16] : r_rdata[15:0];

        w_load_data = r_rdata;
        if (r_ld_ctrl[LD_W]) begin
            w_load_data = r_rdata;
        end else if (r_ld_ctrl[LD_B]) begin
            w_load_data = {{24{w_byte[7]}}, w_byte};
        end else if (r_ld_ctrl[LD_BU]) begin
            w_load_data = {24'h000000, w_byte};
        end else if (r_ld_ctrl[LD_H]) begin
            w_load_data = {{16{w_half[15]}}, w_half};
        end else if (r_ld_ctrl[LD_HU]) begin
            w_load_data = {16'h0000, w_half};
        end
    end

    assign mem_allow_in = w_allow_in;
    assign out_valid    = w_ready_go;
    assign out_result   = w_is_load ? w_load_data : r_result;
    assign out_rf_we    = r_rf_we;
    assign out_rf_waddr = r_rf_waddr;
    assign out_pc       = r_pc;
    assign byp_waddr    = r_rf_waddr;
    assign byp_we       = r_rf_we & (r_state != ST_EMPTY);

`ifdef MEM_LOAD_FWD_EN
    assign byp_busy     = (r_state == ST_WAIT);
    assign byp_data     = w_ready_go ? out_result : r_result;
`else
    assign byp_busy     = (r_state == ST_WAIT) | (w_ready_go & w_is_load);
    assign byp_data     = r_result;
`endif

endmodule

// File: tb/tb_mem_resp_stage.sv
// Testbench for mem_resp_stage: directed scenarios followed by random traffic, all checked
// against a transaction-level reference model. Honours MEM_LOAD_FWD_EN the same way as the design.
`timescale 1ns/1ps
module tb_mem_resp_stage;

    localparam int DISCARD_MAX = 3;
    localparam int CNT_W       = 2;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReadyGo;
    logic [31:0] inPc;
    logic [31:0] inResult;
    logic        inRfWe;
    logic [4:0]  inRfWaddr;
    logic [4:0]  inLdCtrl;
    logic        inReq;
    logic        flush;
    logic        dataOk;
    logic [31:0] rdata;
    logic        memAllowIn;
    logic        wbAllowIn;
    logic        outValid;
    logic [31:0] outResult;
    logic        outRfWe;
    logic [4:0]  outRfWaddr;
    logic [31:0] outPc;
    logic [4:0]  bypWaddr;
    logic        bypWe;
    logic        bypBusy;
    logic [31:0] bypData;

    mem_resp_stage #(.DISCARD_MAX(DISCARD_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(inValid), .in_ready_go(inReadyGo), .in_pc(inPc), .in_result(inResult),
        .in_rf_we(inRfWe), .in_rf_waddr(inRfWaddr), .in_ld_ctrl(inLdCtrl), .in_req(inReq),
        .flush(flush), .data_sram_data_ok(dataOk), .data_sram_rdata(rdata),
        .mem_allow_in(memAllowIn), .wb_allow_in(wbAllowIn), .out_valid(outValid),
        .out_result(outResult), .out_rf_we(outRfWe), .out_rf_waddr(outRfWaddr), .out_pc(outPc),
        .byp_waddr(bypWaddr), .byp_we(bypWe), .byp_busy(bypBusy), .byp_data(bypData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic        we;
        logic [4:0]  waddr;
        logic [4:0]  ld;
    } entry_t;

    // Model: the slot is empty (0), awaiting its response (1) or holding a finished result (2);
    // mOwed counts responses still due for instructions that were flushed while waiting.
    int          compared   = 0;
    int          mismatched = 0;
    bit          modelLive  = 0;
    int          mPhase     = 0;
    int          mOwed      = 0;
    entry_t      mEntry;
    logic [31:0] mWord;

    function automatic logic [31:0] loadValue(input logic [4:0] ld, input logic [31:0] addr,
                                              input logic [31:0] word);
        longint v;
        if (ld == 5'b10000) return word;
        if (ld == 5'b01000 || ld == 5'b00100) begin
            v = longint'((word >> (8 * int'(addr[1:0]))) & 32'h0000_00FF);
            if (ld == 5'b01000 && v > 127) v = v - 256;
            return v[31:0];
        end
        v = longint'((word >> (16 * int'(addr[1]))) & 32'h0000_FFFF);
        if (ld == 5'b00010 && v > 32767) v = v - 65536;
        return v[31:0];
    endfunction

    function automatic logic [31:0] expectedResult();
        if (mEntry.ld == 5'b00000) return mEntry.result;
        return loadValue(mEntry.ld, mEntry.result, mWord);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkModel();
        bit          allow;
        bit          busy;
        logic [31:0] bdata;
        if (!modelLive) return;
        allow = (mPhase == 0 || (mPhase == 2 && wbAllowIn)) && !(mOwed > 0 && inReq);
`ifdef MEM_LOAD_FWD_EN
        busy  = (mPhase == 1);
        bdata = (mPhase == 2) ? expectedResult() : mEntry.result;
`else
        busy  = (mPhase == 1) || (mPhase == 2 && mEntry.ld != 5'b00000);
        bdata = mEntry.result;
`endif
        checkOutput("mem_allow_in", 32'(memAllowIn), 32'(allow));
        checkOutput("out_valid", 32'(outValid), 32'(mPhase == 2));
        checkOutput("byp_we", 32'(bypWe), 32'(mEntry.we && mPhase != 0));
        checkOutput("byp_busy", 32'(bypBusy), 32'(busy));
        if (mPhase != 0) begin
            checkOutput("out_rf_we", 32'(outRfWe), 32'(mEntry.we));
            checkOutput("out_rf_waddr", 32'(outRfWaddr), 32'(mEntry.waddr));
            checkOutput("byp_waddr", 32'(bypWaddr), 32'(mEntry.waddr));
            checkOutput("out_pc", outPc, mEntry.pc);
            checkOutput("byp_data", bypData, bdata);
        end
        if (mPhase == 2) begin
            checkOutput("out_result", outResult, expectedResult());
        end
    endtask

    task automatic modelStep();
        bit allow, take, ours, stale, orphan;
        if (reset) begin
            mPhase = 0; mOwed = 0; mWord = '0; modelLive = 1;
            mEntry = '{pc: '0, result: '0, we: 1'b0, waddr: '0, ld: '0};
            return;
        end
        if (!modelLive) return;
        allow  = (mPhase == 0 || (mPhase == 2 && wbAllowIn)) && !(mOwed > 0 && inReq);
        take   = inValid && inReadyGo && allow && !flush;
        ours   = dataOk && mOwed == 0 && mPhase == 1;
        stale  = dataOk && mOwed > 0;
        orphan = flush && mPhase == 1 && !ours;
        if (stale) mOwed = mOwed - 1;
        if (orphan) mOwed = (mOwed + 1 > DISCARD_MAX) ? DISCARD_MAX : mOwed + 1;
        if (ours) mWord = rdata;
        if (flush && mPhase != 0) begin
            mPhase = 0;
        end else if (ours) begin
            mPhase = 2;
        end else if (take) begin
            mEntry = '{pc: inPc, result: inResult, we: inRfWe, waddr: inRfWaddr, ld: inLdCtrl};
            mPhase = inReq ? 1 : 2;
        end else if (mPhase == 2 && wbAllowIn) begin
            mPhase = 0;
        end
    endtask

    // One clock: inputs are already set mid-cycle; returns mid-cycle after the edge.
    task automatic applyStimulus();
        #1;
        checkModel();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        #1;
    endtask

    task automatic setIdle();
        reset = 1'b0; inValid = 1'b0; inReadyGo = 1'b1; inPc = '0; inResult = '0;
        inRfWe = 1'b0; inRfWaddr = '0; inLdCtrl = '0; inReq = 1'b0; flush = 1'b0;
        dataOk = 1'b0; rdata = '0; wbAllowIn = 1'b1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] waddr,
                         input logic [4:0] ld, input logic req);
        inValid = 1'b1; inPc = pc; inResult = res; inRfWe = 1'b1; inRfWaddr = waddr;
        inLdCtrl = ld; inReq = req;
        applyStimulus();
        inValid = 1'b0; inReq = 1'b0;
    endtask

    task automatic respond(input logic [31:0] word);
        dataOk = 1'b1; rdata = word;
        applyStimulus();
        dataOk = 1'b0;
    endtask

    initial begin
        setIdle();
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        checkOutput("reset_out_valid", 32'(outValid), 32'd0);
        checkOutput("reset_byp_we", 32'(bypWe), 32'd0);
        checkOutput("reset_byp_busy", 32'(bypBusy), 32'd0);
        checkOutput("reset_out_result", outResult, 32'd0);
        checkOutput("reset_out_pc", outPc, 32'd0);

        // ALU result passes straight through in one cycle
        issue(32'h0000_0100, 32'h1234_5678, 5'd3, 5'b00000, 1'b0);
        checkOutput("alu_out_valid", 32'(outValid), 32'd1);
        checkOutput("alu_out_result", outResult, 32'h1234_5678);
        checkOutput("alu_byp_we", 32'(bypWe), 32'd1);
        checkOutput("alu_byp_busy", 32'(bypBusy), 32'd0);
        checkOutput("alu_byp_waddr", 32'(bypWaddr), 32'd3);
        applyStimulus();
        checkOutput("alu_drained", 32'(outValid), 32'd0);

        // ld_b on the top byte lane with a three-cycle response
        issue(32'h0000_0104, 32'h0000_2003, 5'd7, 5'b01000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("ldb_wait_allow", 32'(memAllowIn), 32'd0);
            checkOutput("ldb_wait_busy", 32'(bypBusy), 32'd1);
            if (i < 2) applyStimulus();
        end
        respond(32'h8000_0000);
        checkOutput("ldb_valid", 32'(outValid), 32'd1);
        checkOutput("ldb_result", outResult, 32'hFFFF_FF80);
        applyStimulus();

        issue(32'h0000_0108, 32'h0000_4002, 5'd8, 5'b00001, 1'b1);
        respond(32'h8001_0000);
        checkOutput("ldhu_result", outResult, 32'h0000_8001);
        issue(32'h0000_010C, 32'h0000_4002, 5'd9, 5'b00010, 1'b1);
        respond(32'h8001_0000);
        checkOutput("ldh_result", outResult, 32'hFFFF_8001);
`ifdef MEM_LOAD_FWD_EN
        checkOutput("ldh_fwd_busy", 32'(bypBusy), 32'd0);
        checkOutput("ldh_fwd_data", bypData, 32'hFFFF_8001);
`else
        checkOutput("ldh_nofwd_busy", 32'(bypBusy), 32'd1);
`endif
        applyStimulus();

        // Flushed load: its late response must be dropped, the next load gets the second word
        issue(32'h0000_0110, 32'h0000_0000, 5'd10, 5'b10000, 1'b1);
        flush = 1'b1;
        applyStimulus();
        flush = 1'b0;
        inValid = 1'b1; inReq = 1'b1; inLdCtrl = 5'b10000; inRfWe = 1'b1; inRfWaddr = 5'd11;
        inPc = 32'h0000_0114; inResult = 32'h0000_0040;
        dataOk = 1'b1; rdata = 32'hAAAA_AAAA;
        applyStimulus();
        dataOk = 1'b0;
        checkOutput("discard_no_valid", 32'(outValid), 32'd0);
        applyStimulus();
        inValid = 1'b0; inReq = 1'b0;
        respond(32'h5555_5555);
        checkOutput("discard_valid", 32'(outValid), 32'd1);
        checkOutput("discard_result", outResult, 32'h5555_5555);
        applyStimulus();

        // WB back-pressure holds the result for four cycles, then exactly one transfer
        wbAllowIn = 1'b0;
        issue(32'h0000_0118, 32'hCAFE_F00D, 5'd12, 5'b00000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_valid", 32'(outValid), 32'd1);
            checkOutput("stall_result", outResult, 32'hCAFE_F00D);
            checkOutput("stall_allow", 32'(memAllowIn), 32'd0);
            if (i < 3) applyStimulus();
        end
        wbAllowIn = 1'b1;
        applyStimulus();
        checkOutput("stall_released", 32'(outValid), 32'd0);

        // Reset while waiting, then a stray response must be ignored
        issue(32'h0000_011C, 32'h0000_0000, 5'd13, 5'b10000, 1'b1);
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        respond(32'h1111_1111);
        checkOutput("stray_valid", 32'(outValid), 32'd0);
        checkOutput("stray_busy", 32'(bypBusy), 32'd0);

        for (int n = 0; n < 800; n++) begin
            int k;
            k = int'($urandom_range(0, 5));
            inValid   = 1'($urandom_range(0, 1));
            inReadyGo = ($urandom_range(0, 4) != 0);
            inPc      = $urandom;
            inResult  = $urandom;
            inRfWe    = 1'($urandom_range(0, 1));
            inRfWaddr = 5'($urandom_range(0, 31));
            inLdCtrl  = (k == 0) ? 5'b00000 : 5'(1 << (k - 1));
            inReq     = (k != 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 7) == 0);
            wbAllowIn = ($urandom_range(0, 3) != 0);
            dataOk    = (mPhase == 1 || mOwed > 0) ? ($urandom_range(0, 2) == 0)
                                                   : ($urandom_range(0, 19) == 0);
            rdata     = $urandom;
            reset     = ($urandom_range(0, 199) == 0);
            applyStimulus();
        end
        setIdle();
        applyStimulus();
        applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_resp_stage.md
MEM_RESP_STAGE -- requirements
Module: mem_resp_stage

Interface
REQ-001 Parameter DISCARD_MAX, default 3, max flushed-but-outstanding memory responses tracked (1..15).
REQ-002 Parameter CNT_W, default 2, discard counter width; SHALL satisfy 2^CNT_W > DISCARD_MAX.
REQ-003 One clock; reset is synchronous and active-high. Ports: clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 in_valid  in  1  EX stage holds a valid instruction; in_ready_go  in  1  EX ready to hand over.
REQ-006 in_pc  in  32  PC; in_result  in  32  ALU result / effective address; in_rf_we  in  1; in_rf_waddr  in  5.
REQ-007 in_ld_ctrl  in  5  one-hot {ld_w, ld_b, ld_bu, ld_h, ld_hu}, all-zero = not a load; in_req  in  1  EX issued a data request for this instruction.
REQ-008 flush  in  1  cancel instruction held in this stage.
REQ-009 data_sram_data_ok  in  1  response strobe; data_sram_rdata  in  32  response word.
REQ-010 mem_allow_in  out  1; wb_allow_in  in  1; out_valid  out  1  result valid to WB.
REQ-011 out_result  out  32; out_rf_we  out  1; out_rf_waddr  out  5; out_pc  out  32.
REQ-012 byp_waddr  out  5; byp_we  out  1; byp_busy  out  1  result not yet usable; byp_data  out  32.

Function
REQ-013 Stage register SHALL load in_* fields when in_valid & in_ready_go & mem_allow_in; latency one cycle for non-requests.
REQ-014 States: EMPTY, WAIT (request outstanding, no data), DONE (result ready); load from EMPTY/DONE goes to WAIT if in_req, else DONE.
REQ-015 WAIT -> DONE on data_sram_data_ok with discard counter zero; rdata SHALL be captured into a hold register same edge.
REQ-016 DONE -> EMPTY when wb_allow_in and no new entry; DONE/EMPTY -> WAIT/DONE on new entry.
REQ-017 mem_ready_go = (state==DONE); mem_allow_in = EMPTY | (DONE & wb_allow_in); out_valid = (state==DONE).
REQ-018 Load extraction on captured word, byte lane in_result[1:0], half lane in_result[1]; ld_b/ld_h sign-extend, ld_bu/ld_hu zero-extend, ld_w unchanged.
REQ-019 out_result = extracted load data if ld_ctrl nonzero, else stored in_result.
REQ-020 flush in WAIT: state -> EMPTY, discard counter +1; flush in DONE: state -> EMPTY, counter unchanged.
REQ-021 data_ok while counter>0 SHALL decrement counter and be ignored; data_ok and flush same cycle in WAIT: response consumed (counter unchanged), state -> EMPTY.
REQ-022 mem_allow_in SHALL be 0 while counter>0 and in_req; counter SHALL saturate at DISCARD_MAX.
REQ-023 Simultaneous data_ok (counter 0) and wb_allow_in: DONE reached first; no same-cycle pass-through of rdata to WB.
REQ-024 byp_we = rf_we & state!=EMPTY; byp_waddr = stored rf_waddr; byp_busy = (state==WAIT).

Reset
REQ-025 On reset: state EMPTY, discard counter 0, out_valid 0, byp_we 0, byp_busy 0, all data registers 0.
REQ-026 Reset mid-WAIT SHALL clear counter; later stray data_ok with state EMPTY and counter 0 is ignored.

Configuration
REQ-027 Macro MEM_LOAD_FWD_EN: defined -> byp_data = out_result in DONE, byp_busy=0 in DONE.
REQ-028 Not defined -> byp_busy=1 whenever a load occupies the stage (WAIT or DONE); byp_data = stored in_result.

Verification
REQ-029 ALU op in_result=0x1234_5678, rf_waddr=3, wb_allow_in=1 -> next cycle out_valid=1, out_result=0x1234_5678, byp_we=1, byp_busy=0.
REQ-030 ld_b addr low=2'b11, rdata=0x8000_0000, data_ok 3 cycles after entry -> WAIT 3 cycles with mem_allow_in=0, then out_result=0xFFFF_FF80.
REQ-031 ld_hu addr low=2'b10, rdata=0x8001_0000 -> out_result=0x0000_8001; ld_h same -> 0xFFFF_8001.
REQ-032 Load in WAIT flushed, next load enters, first data_ok=0xAAAA_AAAA then data_ok=0x5555_5555 -> first discarded, out_result from 0x5555_5555.
REQ-033 DONE with wb_allow_in=0 for 4 cycles -> outputs stable, mem_allow_in=0; release -> one transfer.
REQ-034 Load DONE, MEM_LOAD_FWD_EN defined -> byp_busy=0, byp_data=loaded value; undefined -> byp_busy=1.
